// File: rtl/traffic_ctrl_2way_if.sv
// Signal bundle for traffic_ctrl_2way: sensor input(s), light outputs,
// per-road countdowns, their 7-segment digits and the 1 s tick.
// The night input exists only when TRAFFIC_NIGHT_FLASH_EN is defined.
interface traffic_ctrl_2way_if #(
  parameter int CNT_W = 6
);
  logic             C;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic             night;
`endif
  logic [2:0]       light_hwy;
  logic [2:0]       light_farm;
  logic [CNT_W-1:0] cnt_hwy;
  logic [CNT_W-1:0] cnt_farm;
  logic [6:0]       seg_hwy;
  logic [6:0]       seg_farm;
  logic             tick;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  modport master (
    input  C, night,
    output light_hwy, light_farm, cnt_hwy, cnt_farm, seg_hwy, seg_farm, tick
  );
  modport slave (
    output C, night,
    input  light_hwy, light_farm, cnt_hwy, cnt_farm, seg_hwy, seg_farm, tick
  );
`else
  modport master (
    input  C,
    output light_hwy, light_farm, cnt_hwy, cnt_farm, seg_hwy, seg_farm, tick
  );
  modport slave (
    output C,
    input  light_hwy, light_farm, cnt_hwy, cnt_farm, seg_hwy, seg_farm, tick
  );
`endif
endinterface

// File: rtl/traffic_ctrl_2way.sv
// Two-road (highway/farm) intersection controller. A six-phase machine
// with all-red clearance advances on a 1 s tick from a prescaler; highway
// green is extended (held) until the farm sensor C requests service.
// Each road gets a seconds-remaining countdown and a registered active-low
// 7-segment digit. Optional night flashing mode: TRAFFIC_NIGHT_FLASH_EN.
module traffic_ctrl_2way #(
  parameter int TICK_DIV     = 50000000,
  parameter int HWY_GREEN_S  = 5,
  parameter int FARM_GREEN_S = 4,
  parameter int YEL_S        = 3,
  parameter int ALLRED_S     = 1,
  parameter int CNT_W        = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_ctrl_2way_if.master  bus
);

  typedef enum logic [2:0] {
    S_HG  = 3'd0,
    S_HY  = 3'd1,
    S_AR1 = 3'd2,
    S_FG  = 3'd3,
    S_FY  = 3'd4,
    S_AR2 = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
    , S_FLASH = 3'd6
`endif
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_HG    = CNT_W'(HWY_GREEN_S);
  localparam logic [CNT_W-1:0] D_FG    = CNT_W'(FARM_GREEN_S);
  localparam logic [CNT_W-1:0] D_YEL   = CNT_W'(YEL_S);
  localparam logic [CNT_W-1:0] D_AR    = CNT_W'(ALLRED_S);
  localparam logic [CNT_W-1:0] SUM_YA  = CNT_W'(YEL_S + ALLRED_S);
  localparam logic [CNT_W-1:0] SUM_FYA = CNT_W'(FARM_GREEN_S + YEL_S + ALLRED_S);
  localparam logic [CNT_W-1:0] SUM_HYA = CNT_W'(HWY_GREEN_S + YEL_S + ALLRED_S);
  localparam logic [6:0]       SEG_DASH = 7'b0111111;

  state_e           state, nxt_state;
  logic [CNT_W-1:0] remain, nxt_remain;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             flash_on, nxt_flash;
  logic [2:0]       light_hwy_q, light_farm_q;
  logic [CNT_W-1:0] cnt_hwy, cnt_farm;
  logic [6:0]       seg_hwy_q, seg_farm_q;

  // Duration loaded on entry to a phase.
  function automatic logic [CNT_W-1:0] dur_of(state_e s);
    case (s)
      S_HG:         return D_HG;
      S_HY, S_FY:   return D_YEL;
      S_FG:         return D_FG;
      default:      return D_AR;
    endcase
  endfunction

  // Fixed phase order once the current phase has expired.
  function automatic state_e succ(state_e s);
    case (s)
      S_HG:    return S_HY;
      S_HY:    return S_AR1;
      S_AR1:   return S_FG;
      S_FG:    return S_FY;
      S_FY:    return S_AR2;
      default: return S_HG;
    endcase
  endfunction

  function automatic logic is_legal(state_e s);
    case (s)
      S_HG, S_HY, S_AR1, S_FG, S_FY, S_AR2: return 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_FLASH: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // {hwy, farm} lamps for a phase; anything unexpected shows all red.
  function automatic logic [5:0] light_of(state_e s, logic fl);
    case (s)
      S_HG:    return {3'b001, 3'b100};
      S_HY:    return {3'b010, 3'b100};
      S_FG:    return {3'b100, 3'b001};
      S_FY:    return {3'b100, 3'b010};
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_FLASH: return fl ? {3'b010, 3'b010} : 6'b000000;
`endif
      default: return {3'b100, 3'b100};
    endcase
  endfunction

  // Active-low {g..a}; zero means "indefinite" and shows a dash like >9.
  function automatic logic [6:0] seg_of(logic [CNT_W-1:0] v);
    logic [3:0] d;
    d = v[3:0];
    if (v == '0 || v > CNT_W'(9)) return SEG_DASH;
    case (d)
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  assign tick = (presc == PRESC_MAX);

  // Free-running 1 s prescaler; wraps on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Next phase/remain: decisions happen only on tick, except illegal-state recovery.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    nxt_state  = state;
    nxt_remain = remain;
    nxt_flash  = flash_on;
    if (tick) begin
      if (state == S_HG && remain <= ONE) begin
        if (bus.C) begin
          nxt_state  = S_HY;
          nxt_remain = D_YEL;
        end else begin
          nxt_remain = '0;
        end
      end else if (remain > ONE) begin
        nxt_remain = remain - ONE;
      end else begin
        nxt_state  = succ(state);
        nxt_remain = dur_of(succ(state));
      end
    end
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (tick && bus.night) begin
      nxt_state = S_FLASH;
      nxt_flash = (state == S_FLASH) ? ~flash_on : 1'b1;
    end else if (tick && state == S_FLASH) begin
      nxt_state  = S_AR2;
      nxt_remain = D_AR;
    end
`endif
    if (!is_legal(state)) begin
      nxt_state  = S_AR2;
      nxt_remain = D_AR;
    end
  end

  // Phase register with lamps registered alongside so they never lag the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_HG;
      remain       <= D_HG;
      flash_on     <= 1'b0;
      light_hwy_q  <= 3'b001;
      light_farm_q <= 3'b100;
    end else begin
      state        <= nxt_state;
      remain       <= nxt_remain;
      flash_on     <= nxt_flash;
      {light_hwy_q, light_farm_q} <= light_of(nxt_state, nxt_flash);
    end
  end

  // Seconds until each road's colour changes, derived from phase and remain.
  always_comb begin
    cnt_hwy  = '0;
    cnt_farm = '0;
    case (state)
      S_HG: begin
        cnt_hwy  = remain;
        cnt_farm = (remain == '0) ? '0 : remain + SUM_YA;
      end
      S_HY: begin
        cnt_hwy  = remain;
        cnt_farm = remain + D_AR;
      end
      S_AR1: begin
        cnt_hwy  = remain + SUM_FYA;
        cnt_farm = remain;
      end
      S_FG: begin
        cnt_hwy  = remain + SUM_YA;
        cnt_farm = remain;
      end
      S_FY: begin
        cnt_hwy  = remain + D_AR;
        cnt_farm = remain;
      end
      S_AR2: begin
        cnt_hwy  = remain;
        cnt_farm = remain + SUM_HYA;
      end
      default: ;
    endcase
  end

  // Registered digit decode, one cycle behind the counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_hwy_q  <= seg_of(D_HG);
      seg_farm_q <= seg_of(SUM_HYA);
    end else begin
      seg_hwy_q  <= seg_of(cnt_hwy);
      seg_farm_q <= seg_of(cnt_farm);
    end
  end

  assign bus.light_hwy  = light_hwy_q;
  assign bus.light_farm = light_farm_q;
  assign bus.cnt_hwy    = cnt_hwy;
  assign bus.cnt_farm   = cnt_farm;
  assign bus.seg_hwy    = seg_hwy_q;
  assign bus.seg_farm   = seg_farm_q;
  assign bus.tick       = tick;

endmodule

// File: tb/tb_traffic_ctrl_2way.sv
// Self-checking bench for traffic_ctrl_2way with TICK_DIV=4. A phase-table
// reference model derives countdowns by walking future phases until each
// road's lamp colour changes; digits are compared one cycle late.
module tb_traffic_ctrl_2way;

  localparam int TD = 4;
  localparam int H  = 5;
  localparam int F  = 4;
  localparam int Y  = 3;
  localparam int A  = 1;
  localparam int CW = 6;
  localparam int P_FLASH = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_ctrl_2way_if #(.CNT_W(CW)) bus ();

  traffic_ctrl_2way #(
    .TICK_DIV(TD), .HWY_GREEN_S(H), .FARM_GREEN_S(F),
    .YEL_S(Y), .ALLRED_S(A), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase index 0..5 = HG,HY,AR1,FG,FY,AR2 (6 = flashing).
  int   m_p, m_rem, m_presc;
  bit   m_flash_on;
  logic [6:0] seg_prev_h, seg_prev_f;

  function automatic int dur_m(int p);
    case (p)
      0: return H;
      1, 4: return Y;
      3: return F;
      default: return A;
    endcase
  endfunction

  function automatic logic [2:0] lamp_m(int p, bit hwy);
    case (p)
      0: return hwy ? 3'b001 : 3'b100;
      1: return hwy ? 3'b010 : 3'b100;
      3: return hwy ? 3'b100 : 3'b001;
      4: return hwy ? 3'b100 : 3'b010;
      P_FLASH: return m_flash_on ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  // Seconds until this road's lamp differs: current remain plus whole later phases.
  function automatic int until_change(int p, int rem, bit hwy);
    int sum, q;
    if (p == P_FLASH || (p == 0 && rem == 0)) return 0;
    sum = rem;
    q = (p + 1) % 6;
    while (lamp_m(q, hwy) == lamp_m(p, hwy)) begin
      sum += dur_m(q);
      q = (q + 1) % 6;
    end
    return sum;
  endfunction

  function automatic logic [6:0] seg_m(int v, bit indef);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (indef || v > 9) return 7'b0111111;
    return ~tbl[v];
  endfunction

  function automatic bit indef_m();
    return (m_p == P_FLASH) || (m_p == 0 && m_rem == 0);
  endfunction

  task automatic model_reset();
    m_p = 0;
    m_rem = H;
    m_presc = 0;
    m_flash_on = 1'b0;
    seg_prev_h = seg_m(H, 1'b0);
    seg_prev_f = seg_m(H + Y + A, 1'b0);
  endtask

  task automatic model_tick();
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (bus.night) begin
      m_flash_on = (m_p == P_FLASH) ? !m_flash_on : 1'b1;
      m_p = P_FLASH;
      return;
    end
    if (m_p == P_FLASH) begin
      m_p = 5;
      m_rem = A;
      return;
    end
`endif
    if (m_p == 0 && m_rem <= 1) begin
      if (bus.C) begin
        m_p = 1;
        m_rem = Y;
      end else begin
        m_rem = 0;
      end
    end else if (m_rem > 1) begin
      m_rem--;
    end else begin
      m_p = (m_p + 1) % 6;
      m_rem = dur_m(m_p);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int ch, cf;
    ch = until_change(m_p, m_rem, 1'b1);
    cf = until_change(m_p, m_rem, 1'b0);
    check("tick", bus.tick, (m_presc == TD - 1));
    check("light_hwy", bus.light_hwy, lamp_m(m_p, 1'b1));
    check("light_farm", bus.light_farm, lamp_m(m_p, 1'b0));
    check("cnt_hwy", bus.cnt_hwy, ch);
    check("cnt_farm", bus.cnt_farm, cf);
    check("seg_hwy", bus.seg_hwy, seg_prev_h);
    check("seg_farm", bus.seg_farm, seg_prev_f);
    if (m_p != P_FLASH)
      check("both_nonred", (bus.light_hwy != 3'b100) && (bus.light_farm != 3'b100), 1'b0);
    seg_prev_h = seg_m(ch, indef_m());
    seg_prev_f = seg_m(cf, indef_m());
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (m_presc == TD - 1) model_tick();
    m_presc = (m_presc + 1) % TD;
    #1;
    check_all();
  endtask

  initial begin
    int n;
    bus.C = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    bus.night = 1'b0;
`endif
    model_reset();
    #12;
    check_all();
    check("reset_cnt_hwy", bus.cnt_hwy, 5);
    check("reset_cnt_farm", bus.cnt_farm, 9);
    @(negedge clk);
    rst_n = 1'b1;

    // Sensor held: more than one full 17-tick cycle.
    bus.C = 1'b1;
    repeat (17 * TD + 8) step();

    // No demand: highway green holds with indefinite counts.
    bus.C = 1'b0;
    repeat (20 * TD) step();
    check("hold_light_hwy", bus.light_hwy, 3'b001);
    check("hold_cnt_hwy", bus.cnt_hwy, 0);
    check("hold_seg_farm", bus.seg_farm, 7'b0111111);

    // Raise C mid-second; HY only on the following tick.
    n = 0;
    while (m_presc != 1 && n < 2 * TD) begin step(); n++; end
    bus.C = 1'b1;
    step();
    check("no_early_hy", bus.light_hwy, 3'b001);
    repeat (3 * TD) step();

    // Random sensor activity.
    repeat (600) begin
      bus.C = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset in the middle of farm yellow.
    bus.C = 1'b1;
    n = 0;
    while (m_p != 4 && n < 40 * TD) begin step(); n++; end
    check("reach_fy", bus.light_farm, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_hwy", bus.light_hwy, 3'b001);
    check("async_rst_farm", bus.light_farm, 3'b100);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * TD) step();

`ifdef TRAFFIC_NIGHT_FLASH_EN
    // Night flashing entered from farm green, then back through all-red.
    n = 0;
    while (m_p != 3 && n < 40 * TD) begin step(); n++; end
    check("reach_fg", bus.light_farm, 3'b001);
    bus.night = 1'b1;
    repeat (5 * TD) step();
    bus.night = 1'b0;
    repeat (4 * TD) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
